// File: rtl/ivs_sched_pkg.sv
// Shared constants for the round-robin grant scheduler: state encoding, defaults and
// index-width helper.
package ivs_sched_pkg;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StOwn  = 1'b1;

  localparam int unsigned DefaultN       = 32;
  localparam int unsigned DefaultHoldMax = 0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefaultIdxW = idx_width(DefaultN);

endpackage

// File: rtl/ivs_first_one_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant set bit of
// vec_i and whether any bit is set.
module ivs_first_one_enc #(
  parameter int unsigned N     = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ivs_rr_grant_sched.sv
// Round-robin grant scheduler sharing one resource among N requesters, with an optional
// hold limit. Define IVS_RR_SCHED_B2B_EN to hand the grant over without an idle bubble.
module ivs_rr_grant_sched
  import ivs_sched_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned IDX_W    = DefaultIdxW,
  parameter int unsigned HOLD_MAX = DefaultHoldMax
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_oh,
  output logic             gnt_new,
  output logic             forced_rel
);

  localparam int unsigned      CntW   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]     gnt_oh_q, gnt_oh_d;
  logic             gnt_new_q, gnt_new_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             owning;
  logic             expire;
  logic             release_now;
  logic [IDX_W-1:0] nxt_ptr;
  logic [N-1:0]     sel_req;
  logic [IDX_W-1:0] sel_ptr;
  logic [N-1:0]     ptr_mask;
  logic [N-1:0]     masked;
  logic [IDX_W-1:0] m_idx, f_idx, sel_idx;
  logic             m_vld, f_vld;
  logic [N-1:0]     sel_oh;

  assign owning      = (state_q == StOwn);
  assign expire      = (HOLD_MAX != 0) && (cnt_q == CntMax);
  assign release_now = owning && (rel || expire);
  assign nxt_ptr     = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

`ifdef IVS_RR_SCHED_B2B_EN
  // While owning, the encoders look ahead for the successor, skipping the current owner.
  assign sel_req = owning ? (req & ~gnt_oh_q) : req;
  assign sel_ptr = owning ? nxt_ptr : ptr_q;
`else
  assign sel_req = req;
  assign sel_ptr = ptr_q;
`endif

  always_comb begin
    ptr_mask = '0;
    for (int i = 0; i < N; i++) begin
      ptr_mask[i] = (i >= int'(sel_ptr));
    end
  end

  assign masked = sel_req & ptr_mask;

  ivs_first_one_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc_masked (
    .vec_i (masked),
    .idx_o (m_idx),
    .vld_o (m_vld)
  );

  ivs_first_one_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc_full (
    .vec_i (sel_req),
    .idx_o (f_idx),
    .vld_o (f_vld)
  );

  assign sel_idx = m_vld ? m_idx : f_idx;
  assign sel_oh  = {{(N - 1){1'b0}}, 1'b1} << sel_idx;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    gnt_new_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (f_vld) begin
          state_d   = StOwn;
          gnt_idx_d = sel_idx;
          gnt_oh_d  = sel_oh;
          gnt_new_d = 1'b1;
          cnt_d     = '0;
        end
      end
      StOwn: begin
        if (release_now) begin
          state_d   = StIdle;
          ptr_d     = nxt_ptr;
          gnt_idx_d = '0;
          gnt_oh_d  = '0;
          cnt_d     = '0;
`ifdef IVS_RR_SCHED_B2B_EN
          if (f_vld) begin
            state_d   = StOwn;
            gnt_idx_d = sel_idx;
            gnt_oh_d  = sel_oh;
            gnt_new_d = 1'b1;
          end
`endif
        end else if ((HOLD_MAX != 0) && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      gnt_new_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      gnt_new_q <= gnt_new_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_vld    = owning;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_oh     = gnt_oh_q;
  assign gnt_new    = gnt_new_q;
  // rel wins over expiry, so a coincident release is never reported as forced.
  assign forced_rel = owning && expire && !rel;

endmodule

// File: tb/tb_ivs_rr_grant_sched.sv
// Bench for ivs_rr_grant_sched: two instances (unlimited hold and HOLD_MAX=4) share one
// stimulus stream and are checked every cycle against a rotating-search reference model.
module tb_ivs_rr_grant_sched;

  localparam int N     = 32;
  localparam int HoldA = 0;
  localparam int HoldB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] req = '0;
  logic rel = 1'b0;

  logic [1:0]       vld, nw, fr;
  logic [1:0][4:0]  idx;
  logic [1:0][31:0] oh;

  ivs_rr_grant_sched #(.N(32), .IDX_W(5), .HOLD_MAX(HoldA)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rel        (rel),
    .gnt_vld    (vld[0]),
    .gnt_idx    (idx[0]),
    .gnt_oh     (oh[0]),
    .gnt_new    (nw[0]),
    .forced_rel (fr[0])
  );

  ivs_rr_grant_sched #(.N(32), .IDX_W(5), .HOLD_MAX(HoldB)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .rel        (rel),
    .gnt_vld    (vld[1]),
    .gnt_idx    (idx[1]),
    .gnt_oh     (oh[1]),
    .gnt_new    (nw[1]),
    .forced_rel (fr[1])
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner, rotating start point and cycles spent owning.
  typedef struct {
    bit own;
    int idx;
    int ptr;
    int cnt;
    bit nw;
  } ms_t;

  ms_t m[2];

  function automatic ms_t mreset();
    ms_t s;
    s.own = 0; s.idx = 0; s.ptr = 0; s.cnt = 0; s.nw = 0;
    return s;
  endfunction

  function automatic int pick(input logic [31:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  function automatic ms_t mstep(input ms_t s, input int hold, input logic [31:0] r,
                                input logic l);
    ms_t n;
    logic [31:0] rest;
    n = s;
    n.nw = 0;
    rest = r;
    if (!s.own) begin
      if (r != 0) begin
        n.own = 1; n.idx = pick(r, s.ptr); n.nw = 1; n.cnt = 0;
      end
    end else if (l || (hold > 0 && s.cnt == hold - 1)) begin
      n.ptr = (s.idx + 1) % N; n.cnt = 0; n.own = 0; n.idx = 0;
`ifdef IVS_RR_SCHED_B2B_EN
      rest[s.idx] = 1'b0;
      if (rest != 0) begin
        n.own = 1; n.idx = pick(rest, n.ptr); n.nw = 1;
      end
`endif
    end else begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], HoldA, req, rel);
      m[1] <= mstep(m[1], HoldB, req, rel);
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int h;
      logic [31:0] e_oh;
      h = (k == 0) ? HoldA : HoldB;
      e_oh = m[k].own ? (32'd1 << m[k].idx) : 32'd0;
      chk($sformatf("dut%0d.gnt_vld", k), {31'd0, vld[k]}, {31'd0, m[k].own});
      chk($sformatf("dut%0d.gnt_idx", k), {27'd0, idx[k]}, m[k].own ? m[k].idx : 0);
      chk($sformatf("dut%0d.gnt_oh", k), oh[k], e_oh);
      chk($sformatf("dut%0d.gnt_new", k), {31'd0, nw[k]}, {31'd0, m[k].nw});
      chk($sformatf("dut%0d.forced_rel", k), {31'd0, fr[k]},
          {31'd0, m[k].own && h > 0 && m[k].cnt == h - 1 && !rel});
    end
  end

  int q0[$];
  always @(negedge clk) if (nw[0]) q0.push_back(int'(idx[0]));

  // Drive inputs just after a rising edge; return just after the following falling edge.
  task automatic step(input logic [31:0] r, input logic l);
    @(posedge clk);
    #1;
    req = r;
    rel = l;
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) step(32'd0, 1'b1);
    q0.delete();
  endtask

  logic va[0:10], fa[0:10], na[0:10];
  int gaps;
  int e1[4] = '{0, 2, 0, 2};
  int e5[4] = '{0, 1, 0, 1};

  initial begin
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    q0.delete();

    // Two requesters, released right after each grant.
    for (int i = 0; i < 10; i++) step(32'h0000_0005, 1'b1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1.grant%0d", i), (i < q0.size()) ? q0[i] : 32'hDEAD, e1[i]);

    // Pointer wrap from 31 back to 0.
    settle();
    step(32'h8000_0000, 1'b0);
    step(32'h8000_0000, 1'b0);
    chk("t2.oh31", oh[0], 32'h8000_0000);
    step(32'h8000_0000, 1'b0);
    step(32'h8000_0001, 1'b1);
    for (int i = 0; i < 4; i++) step(32'h8000_0001, 1'b0);
    chk("t2.first", (q0.size() > 0) ? q0[0] : 32'hDEAD, 31);
    chk("t2.wrap", (q0.size() > 1) ? q0[1] : 32'hDEAD, 0);

    // Hold limit of 4 on instance b; instance a keeps the grant.
    settle();
    for (int j = 0; j < 11; j++) begin
      step(32'h0000_0010, 1'b0);
      va[j] = vld[1]; fa[j] = fr[1]; na[j] = nw[1];
    end
    chk("t3.vld_run", {28'd0, va[1] & va[2] & va[3] & va[4]}, 32'd1);
    chk("t3.vld_drop", {31'd0, va[5]}, 32'd0);
    chk("t3.forced_early", {31'd0, fa[3]}, 32'd0);
    chk("t3.forced", {31'd0, fa[4]}, 32'd1);
    chk("t3.regrant", {31'd0, na[6]}, 32'd1);
    chk("t3.unlimited_vld", {31'd0, vld[0]}, 32'd1);
    chk("t3.unlimited_idx", {27'd0, idx[0]}, 32'd4);

    // Owner 3 withdraws its request but keeps the grant until rel.
    settle();
    step(32'h0000_0008, 1'b0);
    for (int i = 0; i < 6; i++) step(32'd0, 1'b0);
    chk("t4.kept_vld", {31'd0, vld[0]}, 32'd1);
    chk("t4.kept_idx", {27'd0, idx[0]}, 32'd3);
    step(32'd0, 1'b1);
    step(32'd0, 1'b0);
    chk("t4.released", {31'd0, vld[0]}, 32'd0);

    // Asynchronous reset while owning 7.
    settle();
    step(32'h0000_0080, 1'b0);
    step(32'h0000_0080, 1'b0);
    chk("t5.own7", {27'd0, idx[0]}, 32'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("t5.rst_vld", {30'd0, vld}, 32'd0);
    chk("t5.rst_idx", {22'd0, idx}, 32'd0);
    chk("t5.rst_oh", oh[0] | oh[1], 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t5.regrant_vld", {31'd0, vld[0]}, 32'd1);
    chk("t5.regrant_idx", {27'd0, idx[0]}, 32'd7);
    chk("t5.regrant_new", {31'd0, nw[0]}, 32'd1);

    // Back-to-back handover versus the idle bubble.
    settle();
    gaps = 0;
    for (int j = 0; j < 9; j++) begin
      step(32'h0000_0003, 1'b1);
      if (j >= 2 && !vld[0]) gaps++;
    end
`ifdef IVS_RR_SCHED_B2B_EN
    chk("t6.gaps", gaps, 0);
`else
    chk("t6.gaps", gaps, 4);
`endif
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6.grant%0d", i), (i < q0.size()) ? q0[i] : 32'hDEAD, e5[i]);

    // Random traffic.
    settle();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      int mode;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       r = $urandom & $urandom & $urandom;
        1:       r = 32'd1 << $urandom_range(0, 31);
        2:       r = $urandom;
        default: r = 32'd0;
      endcase
      step(r, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
